divisor_pertinencia_trapezio: RTL and testbench

- Sequential divider directly downstream of the ×100 numerator-scaling stage of the trapezoid fuzzifier.
- Takes the two scaled numerators and their slope-width denominators.
- Produces the two membership degrees as integers in 0..100 (percent).
- One shared radix-2 restoring divider is time-multiplexed: numerator 1 first, then numerator 2. This replaces two combinational dividers.

---
 rtl/divisor_pertinencia_trapezio.sv | 146 ++++++++++++++
 tb/tb_divisor_pertinencia_trapezio.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_pertinencia_trapezio.sv
// Shared radix-2 restoring divider turning the two x100-scaled trapezoid numerators
// into membership degrees 0..MAX_PERT, dividing numerator 1 first, then numerator 2.
module divisor_pertinencia_trapezio #(
    parameter int WIDTH    = 32,
    parameter int OUT_W    = 8,
    parameter int MAX_PERT = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] Numerador_1_Mult,
    input  logic [WIDTH-1:0] Numerador_2_Mult,
    input  logic [WIDTH-1:0] Denominador_1,
    input  logic [WIDTH-1:0] Denominador_2,
    output logic [OUT_W-1:0] Pertinencia_1,
    output logic [OUT_W-1:0] Pertinencia_2,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV1 = 2'd1,
        DIV2 = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] num2_q;
    logic [WIDTH-1:0] den1_q;
    logic [WIDTH-1:0] den2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [OUT_W-1:0] pert1_q;
    logic [OUT_W-1:0] pert2_q;
    logic             busy_q;
    logic             done_q;
    logic             div_zero_q;

    logic [WIDTH-1:0] den_cur;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_sub;
    logic             q_bit;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] work_d;

    // work_q shifts the numerator out of its MSB while quotient bits enter at the LSB,
    // so after WIDTH steps it holds the full quotient.
    always_comb begin
        den_cur   = (state_q == DIV2) ? den2_q : den1_q;
        rem_shift = {rem_q, work_q[WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, den_cur};
        q_bit     = (rem_shift >= {1'b0, den_cur});
        rem_d     = q_bit ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        work_d    = {work_q[WIDTH-2:0], q_bit};
    end

    function automatic logic [OUT_W-1:0] saturate(input logic [WIDTH-1:0] quo,
                                                  input logic             den_zero);
        if (den_zero || (quo > WIDTH'(MAX_PERT))) begin
            return OUT_W'(MAX_PERT);
        end
        return quo[OUT_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            work_q     <= '0;
            rem_q      <= '0;
            num2_q     <= '0;
            den1_q     <= '0;
            den2_q     <= '0;
            cnt_q      <= '0;
            pert1_q    <= '0;
            pert2_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= DIV1;
                        busy_q     <= 1'b1;
                        work_q     <= Numerador_1_Mult;
                        num2_q     <= Numerador_2_Mult;
                        den1_q     <= Denominador_1;
                        den2_q     <= Denominador_2;
                        rem_q      <= '0;
                        cnt_q      <= CNT_LAST;
                        div_zero_q <= (Denominador_1 == '0) || (Denominador_2 == '0);
                    end
                end
                DIV1: begin
                    if (cnt_q == '0) begin
                        // Last step: commit degree 1, then reload for the second operand set.
                        pert1_q <= saturate(work_d, den1_q == '0);
                        state_q <= DIV2;
                        work_q  <= num2_q;
                        rem_q   <= '0;
                        cnt_q   <= CNT_LAST;
                    end else begin
                        work_q <= work_d;
                        rem_q  <= rem_d;
                        cnt_q  <= cnt_q - CNT_W'(1);
                    end
                end
                DIV2: begin
                    if (cnt_q == '0) begin
                        pert2_q <= saturate(work_d, den2_q == '0);
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        work_q  <= work_d;
                        rem_q   <= rem_d;
                    end else begin
                        work_q <= work_d;
                        rem_q  <= rem_d;
                        cnt_q  <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Pertinencia_1 = pert1_q;
    assign Pertinencia_2 = pert2_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign div_zero      = div_zero_q;

endmodule

// File: tb/tb_divisor_pertinencia_trapezio.sv
// Randomized and directed bench for the time-multiplexed membership-degree divider,
// checked every cycle against a timeline model built on plain integer division.
module tb_divisor_pertinencia_trapezio;

    localparam int WIDTH    = 32;
    localparam int OUT_W    = 8;
    localparam int MAX_PERT = 100;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] n1, n2, d1, d2;
    logic [OUT_W-1:0] p1, p2;
    logic             busy, done, div_zero;

    divisor_pertinencia_trapezio #(
        .WIDTH(WIDTH), .OUT_W(OUT_W), .MAX_PERT(MAX_PERT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .Numerador_1_Mult(n1), .Numerador_2_Mult(n2),
        .Denominador_1(d1), .Denominador_2(d2),
        .Pertinencia_1(p1), .Pertinencia_2(p2),
        .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit tb_end = 1'b0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic longint unsigned ref_pert(input longint unsigned n, input longint unsigned d);
        longint unsigned q;
        if (d == 0) return MAX_PERT;
        q = n / d;
        return (q > MAX_PERT) ? MAX_PERT : q;
    endfunction

    // Timeline model: an accepted request owns the divider for 2*WIDTH+2 cycles;
    // degree 1 appears WIDTH edges after acceptance, degree 2 and done after 2*WIDTH.
    bit              m_active;
    int              m_t;
    longint unsigned r1, r2;
    longint unsigned exp_p1, exp_p2;
    bit              exp_busy, exp_done, exp_dz;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_t      <= 0;
            exp_p1   <= 0;
            exp_p2   <= 0;
            exp_busy <= 1'b0;
            exp_done <= 1'b0;
            exp_dz   <= 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_t      <= 0;
                r1       <= ref_pert(n1, d1);
                r2       <= ref_pert(n2, d2);
                exp_dz   <= (d1 == 0) || (d2 == 0);
                exp_busy <= 1'b1;
            end
        end else begin
            m_t <= m_t + 1;
            if (m_t == WIDTH - 1) exp_p1 <= r1;
            if (m_t == 2 * WIDTH - 1) begin
                exp_p2   <= r2;
                exp_done <= 1'b1;
            end
            if (m_t == 2 * WIDTH) begin
                m_active <= 1'b0;
                exp_busy <= 1'b0;
                exp_done <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && !tb_end) begin
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("pert1", p1, exp_p1);
            chk("pert2", p2, exp_p2);
            chk("div_zero", div_zero, exp_dz);
        end
    end

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                return;
            end
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                          input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] b2,
                          input longint unsigned e1, input longint unsigned e2,
                          input bit edz);
        bit ok;
        @(negedge clk);
        n1 = a1; d1 = b1; n2 = a2; d2 = b2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        if (ok) begin
            chk("op_pert1", p1, e1);
            chk("op_pert2", p2, e2);
            chk("op_div_zero", div_zero, edz);
        end
        $display("[TB] op N1=%0d D1=%0d N2=%0d D2=%0d -> P1=%0d P2=%0d dz=%0d",
                 a1, b1, a2, b2, p1, p2, div_zero);
    endtask

    task automatic run_rand_op();
        logic [WIDTH-1:0] a1, b1, a2, b2;
        if ($urandom_range(0, 3) == 0) begin
            a1 = $urandom(); b1 = $urandom(); a2 = $urandom(); b2 = $urandom();
        end else begin
            a1 = $urandom_range(0, 15000); b1 = $urandom_range(0, 160);
            a2 = $urandom_range(0, 15000); b2 = $urandom_range(0, 160);
        end
        if ($urandom_range(0, 7) == 0) b1 = '0;
        if ($urandom_range(0, 7) == 0) b2 = '0;
        run_op(a1, b1, a2, b2, ref_pert(a1, b1), ref_pert(a2, b2), (b1 == 0) || (b2 == 0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit ok;
        int t_prev;
        rst_n = 1'b0; start = 1'b0;
        n1 = '0; n2 = '0; d1 = '0; d2 = '0;

        // Hand-computed pins on the reference arithmetic itself.
        chk("ref_50", ref_pert(5000, 100), 50);
        chk("ref_trunc", ref_pert(9999, 100), 99);
        chk("ref_sat", ref_pert(30000, 100), 100);
        chk("ref_dz", ref_pert(700, 0), 100);
        chk("ref_zero", ref_pert(0, 7), 0);
        chk("ref_full", ref_pert(32'hFFFF_FF9C, 32'hFFFF_FFFF), 0);

        repeat (3) @(negedge clk);
        chk("rst_pert1", p1, 0);
        chk("rst_pert2", p2, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_zero, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(5000, 100, 2500, 50, 50, 50, 0);
        run_op(9999, 100, 0, 7, 99, 0, 0);
        run_op(30000, 100, 700, 0, 100, 100, 1);
        run_op(1234, 100, 4321, 100, 12, 43, 0);
        run_op(32'hFFFF_FF9C, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 0, 0, 0);

        // A second start while busy, with different operands, must be ignored.
        @(negedge clk);
        n1 = 8000; d1 = 100; n2 = 600; d2 = 20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        n1 = 100; d1 = 1; n2 = 3; d2 = 1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        if (ok) begin
            chk("ignore_pert1", p1, 80);
            chk("ignore_pert2", p2, 30);
        end
        $display("[TB] ignored-start op -> P1=%0d P2=%0d", p1, p2);

        // Reset in the middle of the second division.
        @(negedge clk);
        n1 = 5000; d1 = 100; n2 = 2500; d2 = 50; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_pert1", p1, 0);
        chk("abort_pert2", p2, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_dz", div_zero, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        $display("[TB] aborted op -> no done observed window complete");
        run_op(7000, 100, 2100, 30, 70, 70, 0);

        // start held high: back-to-back operations every 2*WIDTH+2 cycles.
        @(negedge clk);
        n1 = 4200; d1 = 100; n2 = 900; d2 = 10; start = 1'b1;
        t_prev = -1;
        for (int k = 0; k < 3; k++) begin
            wait_done(ok);
            if (!ok) break;
            if (t_prev >= 0) chk("b2b_period", cyc - t_prev, 2 * WIDTH + 2);
            t_prev = cyc;
            if (k == 2) start = 1'b0;
            $display("[TB] held-start op %0d -> P1=%0d P2=%0d", k, p1, p2);
        end
        start = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 30; i++) run_rand_op();

        repeat (2) @(negedge clk);
        tb_end = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
